// File: rtl/rnn_mem_arbiter_if.sv
// rnn_mem_arbiter_if: bundle of the requester-side and memory-side signals of
// the RNN memory arbiter. The master modport is the arbiter itself. The slave
// modport is the environment: the requesters plus the memory pins.
interface rnn_mem_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 20,
    parameter int LEN_W  = 8
);
    // requester side
    logic [N_REQ-1:0]        req;
    logic [3*N_REQ-1:0]      req_sel;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [LEN_W*N_REQ-1:0]  req_len;
    logic [DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        beat_ack;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    // memory side
    logic                    mce;
    logic [2:0]              msel;
    logic [ADDR_W-1:0]       maddr;
    logic [DATA_W-1:0]       mdata_w;
    logic [DATA_W-1:0]       mdata_r;
    // status
    logic                    busy;

    modport master (
        input  req, req_sel, req_addr, req_len, req_wdata, mdata_r,
        output gnt, beat_ack, done, rvalid, rdata,
        output mce, msel, maddr, mdata_w, busy
    );

    modport slave (
        output req, req_sel, req_addr, req_len, req_wdata, mdata_r,
        input  gnt, beat_ack, done, rvalid, rdata,
        input  mce, msel, maddr, mdata_w, busy
    );
endinterface

// File: rtl/rnn_mem_arbiter.sv
// rnn_mem_arbiter: shares the single RNN memory port among N_REQ requesters.
// A winner is granted for a whole burst of consecutive addresses; read data is
// routed back to the issuing requester through an RD_LAT-deep tag pipeline.
// Optional feature: define RNN_ARB_RR_EN for round-robin arbitration; without
// it, arbitration is fixed priority with index 0 highest.
module rnn_mem_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 20,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    rnn_mem_arbiter_if.master   bus
);

    localparam int         IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [2:0] SEL_WR = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Burst length 0 is treated as a single beat; returns the index of the
    // final beat so the counter can be compared directly against it.
    function automatic logic [LEN_W-1:0] f_last_beat(input logic [LEN_W-1:0] len);
        if (len == '0) begin
            return '0;
        end
        return len - 1'b1;
    endfunction

    // Select codes 110/111 are unused encodings and must never win a grant.
    function automatic logic f_sel_legal(input logic [2:0] sel);
        return (sel[2:1] != 2'b11);
    endfunction

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [N_REQ-1:0]       r_gnt;
    logic [N_REQ-1:0]       w_gnt_nxt;
    logic [LEN_W-1:0]       r_cnt;
    logic [LEN_W-1:0]       w_cnt_nxt;

    logic [IDX_W-1:0]       r_gidx;
    logic [2:0]             r_sel;
    logic [ADDR_W-1:0]      r_base;
    logic [LEN_W-1:0]       r_last;

    logic [N_REQ-1:0]       w_cand;
    logic                   w_any_cand;
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_grant;
    logic                   w_beat;
    logic                   w_last;
    logic                   w_req_g;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_wdata;

    logic [RD_LAT-1:0]      r_tag_vld;
    logic [IDX_W-1:0]       r_tag_idx [RD_LAT];
    logic [N_REQ-1:0]       w_rvalid;

`ifdef RNN_ARB_RR_EN
    logic [IDX_W-1:0]       r_ptr;
`endif

    // Candidate set: requesting and carrying a legal select code.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand[i] = bus.req[i] && f_sel_legal(bus.req_sel[3*i +: 3]);
        end
    end

`ifdef RNN_ARB_RR_EN
    // Round-robin pick: search from the slot after the last winner; walking
    // the order backwards lets the earliest slot in search order win.
    always_comb begin
        w_any_cand = 1'b0;
        w_win_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (w_cand[(int'(r_ptr) + k) % N_REQ]) begin
                w_any_cand = 1'b1;
                w_win_idx  = IDX_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    // Round-robin pointer: starts at the top index so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= IDX_W'(N_REQ - 1);
        end else if (w_grant) begin
            r_ptr <= w_win_idx;
        end
    end
`else
    // Fixed priority pick: the lowest index candidate wins.
    always_comb begin
        w_any_cand = 1'b0;
        w_win_idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_any_cand = 1'b1;
                w_win_idx  = IDX_W'(i);
            end
        end
    end
`endif

    // The granted requester must keep its request up, otherwise the burst aborts.
    assign w_req_g = |(bus.req & r_gnt);

    // FSM next state, grant/counter update and beat issue decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_cand) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = BURST;
                    for (int i = 0; i < N_REQ; i++) begin
                        w_gnt_nxt[i] = (w_win_idx == IDX_W'(i));
                    end
                end
            end
            BURST: begin
                if (!w_req_g) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_beat = 1'b1;
                    if (r_cnt == r_last) begin
                        w_last      = 1'b1;
                        w_gnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register with grant vector and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latch the winner's burst descriptor; only consumed while in BURST.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_gidx <= w_win_idx;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_win_idx == IDX_W'(i)) begin
                    r_sel  <= bus.req_sel[3*i +: 3];
                    r_base <= bus.req_addr[ADDR_W*i +: ADDR_W];
                    r_last <= f_last_beat(bus.req_len[LEN_W*i +: LEN_W]);
                end
            end
        end
    end

    // Read tag pipeline: each read beat enters with its requester index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_idx[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_beat && (r_sel != SEL_WR);
            r_tag_idx[0] <= r_gidx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    // Decode the oldest tag into the per-requester read-valid strobe.
    always_comb begin
        w_rvalid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_tag_vld[RD_LAT-1] && (r_tag_idx[RD_LAT-1] == IDX_W'(i))) begin
                w_rvalid[i] = 1'b1;
            end
        end
    end

    // Write data comes straight from the granted requester's current beat.
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_wdata = bus.req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Address arithmetic wraps naturally at the address width.
    assign w_addr = r_base + ADDR_W'(r_cnt);

    assign bus.gnt      = r_gnt;
    assign bus.beat_ack = w_beat ? r_gnt : '0;
    assign bus.done     = (w_beat && w_last) ? r_gnt : '0;
    assign bus.rvalid   = w_rvalid;
    assign bus.rdata    = bus.mdata_r;
    assign bus.mce      = w_beat;
    assign bus.msel     = w_beat ? r_sel : 3'b000;
    assign bus.maddr    = w_beat ? w_addr : '0;
    assign bus.mdata_w  = w_beat ? w_wdata : '0;
    assign bus.busy     = (r_state == BURST) || (|r_tag_vld);

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// tb_rnn_mem_arbiter: directed bench for rnn_mem_arbiter with a one-cycle
// read-latency memory model whose contents are a fixed function of sel/addr.
module tb_rnn_mem_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 20;
    localparam int LEN_W  = 8;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rnn_mem_arbiter_if #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) bus ();

    rnn_mem_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [19:0] mem_word(input logic [2:0] sel, input logic [16:0] addr);
        return {sel, addr} ^ 20'h5A5A5;
    endfunction

    // Memory: a read beat returns its word at the following rising edge.
    always @(posedge clk) begin
        if (bus.mce && bus.msel != 3'b101) bus.mdata_r <= mem_word(bus.msel, bus.maddr);
        else                              bus.mdata_r <= 20'h0BAD0;
    end

    task automatic set_req(input int i, input logic on, input logic [2:0] sel,
                           input logic [16:0] addr, input logic [7:0] len);
        bus.req[i]            = on;
        bus.req_sel[3*i +: 3] = sel;
        bus.req_addr[17*i +: 17] = addr;
        bus.req_len[8*i +: 8] = len;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [33:0] got;
        reset = 1'b1;
        bus.req = '0; bus.req_sel = '0; bus.req_addr = '0; bus.req_len = '0; bus.req_wdata = '0;
        repeat (2) begin
            @(negedge clk);
            got = {bus.gnt, bus.beat_ack, bus.done, bus.rvalid, bus.mce, bus.msel, bus.maddr, bus.busy};
            n_chk++;
            if (got !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0", got);
            end
        end
        next_cycle;
        reset = 1'b0;
    endtask

    task automatic test_burst(input string name, input int idx, input logic [2:0] sel,
                              input logic [16:0] addr, input logic [7:0] len);
        logic [2:0]  oh;
        int          n;
        logic        rd;
        logic [13:0] got;
        logic [13:0] exp;
        oh = 3'b001 << idx;
        n  = (len == 8'd0) ? 1 : int'(len);
        rd = (sel != 3'b101);
        next_cycle;
        set_req(idx, 1'b1, sel, addr, len);
        bus.req_wdata[20*idx +: 20] = 20'hA0000;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b000 || bus.mce !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pre_grant: gnt %b mce %b expected 000 0", name, bus.gnt, bus.mce);
        end
        for (int c = 0; c <= n + 1; c++) begin
            next_cycle;
            if (c == n) bus.req[idx] = 1'b0;
            bus.req_wdata[20*idx +: 20] = 20'hA0000 + 20'(c);
            @(negedge clk);
            exp = {(c < n) ? oh : 3'b000, (c < n) ? oh : 3'b000, (c == n - 1) ? oh : 3'b000,
                   (rd && c >= 1 && c <= n) ? oh : 3'b000, (c < n), ((c < n) || (rd && c == n))};
            got = {bus.gnt, bus.beat_ack, bus.done, bus.rvalid, bus.mce, bus.busy};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s ctl c%0d: got %b expected %b (gnt ack done rvalid mce busy)", name, c, got, exp);
            end
            if (c < n) begin
                n_chk++;
                if (bus.maddr !== 17'(addr + 17'(c)) || bus.msel !== sel) begin
                    n_fail++;
                    $display("FAIL %s addr c%0d: got %h/%b expected %h/%b", name, c, bus.maddr, bus.msel,
                             17'(addr + 17'(c)), sel);
                end
                if (!rd) begin
                    n_chk++;
                    if (bus.mdata_w !== 20'hA0000 + 20'(c)) begin
                        n_fail++;
                        $display("FAIL %s wdata c%0d: got %h expected %h", name, c, bus.mdata_w, 20'hA0000 + 20'(c));
                    end
                end
            end
            if (rd && c >= 1 && c <= n) begin
                n_chk++;
                if (bus.rdata !== mem_word(sel, 17'(addr + 17'(c - 1)))) begin
                    n_fail++;
                    $display("FAIL %s rdata c%0d: got %h expected %h", name, c, bus.rdata,
                             mem_word(sel, 17'(addr + 17'(c - 1))));
                end
            end
        end
    endtask

`ifndef RNN_ARB_RR_EN
    task automatic test_contention;
        logic [2:0]  e_gnt [6];
        logic [2:0]  e_done [6];
        logic [2:0]  e_rv [6];
        logic [16:0] e_addr [6];
        logic [19:0] e_rd [6];
        logic [9:0]  got;
        logic [9:0]  exp;
        e_gnt  = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000};
        e_done = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000};
        e_rv   = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b000};
        e_addr = '{17'h100, 17'h101, 17'h0, 17'h200, 17'h0, 17'h0};
        e_rd   = '{20'h0, mem_word(3'b000, 17'h100), mem_word(3'b000, 17'h101), 20'h0,
                   mem_word(3'b100, 17'h200), 20'h0};
        next_cycle;
        set_req(0, 1'b1, 3'b000, 17'h100, 8'd2);
        set_req(2, 1'b1, 3'b100, 17'h200, 8'd1);
        for (int c = 0; c < 6; c++) begin
            next_cycle;
            if (c == 2) bus.req[0] = 1'b0;
            if (c == 4) bus.req[2] = 1'b0;
            @(negedge clk);
            exp = {e_gnt[c], e_done[c], e_rv[c], (c != 5)};
            got = {bus.gnt, bus.done, bus.rvalid, bus.busy};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL contention ctl c%0d: got %b expected %b (gnt done rvalid busy)", c, got, exp);
            end
            if (e_gnt[c] != 3'b000) begin
                n_chk++;
                if (bus.mce !== 1'b1 || bus.maddr !== e_addr[c]) begin
                    n_fail++;
                    $display("FAIL contention addr c%0d: got mce %b addr %h expected 1 %h", c, bus.mce, bus.maddr, e_addr[c]);
                end
            end
            if (e_rv[c] != 3'b000) begin
                n_chk++;
                if (bus.rdata !== e_rd[c]) begin
                    n_fail++;
                    $display("FAIL contention rdata c%0d: got %h expected %h", c, bus.rdata, e_rd[c]);
                end
            end
        end
    endtask
`else
    task automatic test_rr;
        logic [2:0] e_gnt [3];
        e_gnt = '{3'b001, 3'b000, 3'b100};
        next_cycle;
        reset = 1'b1;
        next_cycle;
        reset = 1'b0;
        set_req(0, 1'b1, 3'b000, 17'h010, 8'd1);
        set_req(2, 1'b1, 3'b100, 17'h020, 8'd1);
        for (int c = 0; c < 3; c++) begin
            next_cycle;
            @(negedge clk);
            n_chk++;
            if (bus.gnt !== e_gnt[c]) begin
                n_fail++;
                $display("FAIL rr_gnt c%0d: got %b expected %b", c, bus.gnt, e_gnt[c]);
            end
        end
        next_cycle;
        bus.req = '0;
        repeat (2) next_cycle;
    endtask
`endif

    task automatic test_abort;
        int beats = 0;
        int rvs   = 0;
        int dones = 0;
        next_cycle;
        set_req(1, 1'b1, 3'b010, 17'h040, 8'd8);
        for (int c = 0; c < 6; c++) begin
            next_cycle;
            if (c == 2) bus.req[1] = 1'b0;
            @(negedge clk);
            if (bus.beat_ack[1]) beats++;
            if (bus.done != 3'b000) dones++;
            if (bus.rvalid[1]) begin
                n_chk++;
                if (bus.rdata !== mem_word(3'b010, 17'h040 + 17'(rvs))) begin
                    n_fail++;
                    $display("FAIL abort_rdata c%0d: got %h expected %h", c, bus.rdata, mem_word(3'b010, 17'h040 + 17'(rvs)));
                end
                rvs++;
            end
            if (c == 2) begin
                n_chk++;
                if (bus.mce !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_mce_c2: got %b expected 0", bus.mce);
                end
            end
            if (c == 3) begin
                n_chk++;
                if (bus.gnt !== 3'b000) begin
                    n_fail++;
                    $display("FAIL abort_gnt_c3: got %b expected 000", bus.gnt);
                end
            end
        end
        n_chk++;
        if (beats != 2 || rvs != 2 || dones != 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_counts: beats %0d rvalid %0d done %0d busy %b expected 2 2 0 0", beats, rvs, dones, bus.busy);
        end
    endtask

    task automatic test_reserved_sel;
        logic [4:0] got;
        next_cycle;
        set_req(0, 1'b1, 3'b110, 17'h000, 8'd1);
        set_req(1, 1'b1, 3'b111, 17'h001, 8'd1);
        for (int c = 0; c < 4; c++) begin
            next_cycle;
            @(negedge clk);
            got = {bus.gnt, bus.mce, bus.busy};
            n_chk++;
            if (got !== 5'b0) begin
                n_fail++;
                $display("FAIL reserved_sel c%0d: got %b expected 00000 (gnt mce busy)", c, got);
            end
        end
        next_cycle;
        set_req(2, 1'b1, 3'b000, 17'h007, 8'd1);
        next_cycle;
        @(negedge clk);
        n_chk++;
        if (bus.gnt !== 3'b100 || bus.mce !== 1'b1 || bus.maddr !== 17'h007) begin
            n_fail++;
            $display("FAIL reserved_sel_other: got gnt %b mce %b addr %h expected 100 1 00007", bus.gnt, bus.mce, bus.maddr);
        end
        next_cycle;
        bus.req = '0;
        repeat (2) next_cycle;
    endtask

    task automatic test_reset_midburst;
        logic [33:0] got;
        int          late = 0;
        next_cycle;
        set_req(0, 1'b1, 3'b000, 17'h300, 8'd8);
        for (int c = 0; c < 3; c++) begin
            next_cycle;
            @(negedge clk);
        end
        n_chk++;
        if (bus.mce !== 1'b1 || bus.rvalid !== 3'b001) begin
            n_fail++;
            $display("FAIL midburst_pre: mce %b rvalid %b expected 1 001", bus.mce, bus.rvalid);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        got = {bus.gnt, bus.beat_ack, bus.done, bus.rvalid, bus.mce, bus.msel, bus.maddr, bus.busy};
        n_chk++;
        if (got !== 34'd0) begin
            n_fail++;
            $display("FAIL midburst_reset_immediate: got %h expected 0", got);
        end
        bus.req = '0;
        next_cycle;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.rvalid != 3'b000 || bus.mce || bus.gnt != 3'b000 || bus.busy) late++;
            next_cycle;
        end
        n_chk++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL midburst_after_release: active cycles %0d expected 0", late);
        end
    endtask

    initial begin
        test_reset();
        test_burst("read", 1, 3'b000, 17'h00010, 8'd4);
        test_burst("write", 0, 3'b101, 17'h000C0, 8'd64);
        test_burst("wrap", 1, 3'b010, 17'h1FFFE, 8'd3);
        test_burst("len0", 2, 3'b001, 17'h00055, 8'd0);
`ifndef RNN_ARB_RR_EN
        test_contention();
`else
        test_rr();
`endif
        test_abort();
        test_reserved_sel();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rnn_mem_arbiter.md
Name: rnn_mem_arbiter

Overview:
- Shares the RNN's single memory port (mce/msel/maddr/mdata_r/mdata_w) among N_REQ internal requesters: output writeback, weight fetch, bias/LEN fetch.
- Grants one requester at a time for a burst of consecutive addresses and generates the addresses.
- Routes read data back to the requester that issued the read, tagged by a read-latency pipeline.
- Sits between the RNN compute sequencer and the top-level memory pins.

Parameters:
- N_REQ, 3, number of requesters; index 0 has highest fixed priority.
- ADDR_W, 17, memory address width.
- DATA_W, 20, memory data width.
- LEN_W, 8, burst length field width.
- RD_LAT, 1, cycles from a read beat (mce=1) to valid mdata_r at a clk rising edge.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held until burst done.
- req_sel  input  3*N_REQ  per-requester msel code. 000 W_IH, 001 B_IH, 010 W_HH, 011 B_HH, 100 LEN, 101 write H_T.
- req_addr  input  ADDR_W*N_REQ  per-requester burst base address.
- req_len  input  LEN_W*N_REQ  per-requester burst beats; 0 is treated as 1.
- req_wdata  input  DATA_W*N_REQ  per-requester write data for the current beat.
- gnt  output  N_REQ  one-hot grant, held for the whole burst.
- beat_ack  output  N_REQ  one-cycle pulse per issued beat.
- done  output  N_REQ  one-cycle pulse with the last beat of a burst.
- rvalid  output  N_REQ  read data valid for that requester.
- rdata  output  DATA_W  read data; equals mdata_r, qualified by rvalid.
- mce  output  1  memory cycle enable.
- msel  output  3  memory select.
- maddr  output  ADDR_W  memory address.
- mdata_w  output  DATA_W  memory write data.
- mdata_r  input  DATA_W  memory read data.
- busy  output  1  high whenever state is not IDLE or any read is outstanding.

Behaviour:
- Reset values: gnt, beat_ack, done, rvalid, mce, msel, maddr, busy are all 0. The read-tag pipeline is cleared and the state is IDLE. Reset is asynchronous and takes effect immediately, including mid-burst; any outstanding reads are discarded.
- States: IDLE and BURST.
- IDLE:
  - Candidates are requesters with req=1 and req_sel not in {110, 111}. Requests with 11x are never granted.
  - On a rising edge with at least one candidate: register the winner's gnt bit and latch its sel, base and len (len 0 becomes 1). Clear the beat counter cnt. Next state is BURST.
  - mce=0 throughout IDLE.
- BURST, each cycle:
  - mce=1, msel = latched sel, maddr = base + cnt (modulo 2^ADDR_W, so 0x1FFFF wraps to 0x00000).
  - beat_ack[g]=1.
  - mdata_w = req_wdata[g], combinational. The requester advances its data on beat_ack.
  - cnt increments at the edge.
  - After the beat where cnt = len-1: done[g]=1, gnt clears, next state is IDLE. This gives a minimum one-cycle gap between bursts.
- Abort: if req[g] is sampled low in BURST, the current cycle issues no beat (mce=0). gnt clears, no done pulse, return to IDLE. Reads already issued still return.
- Read return:
  - Each beat with msel≠101 pushes tag g into an RD_LAT-deep shift register.
  - RD_LAT cycles later, rvalid[g]=1 and rdata=mdata_r.
  - Write beats (101) push an empty tag and produce no rvalid.
- Simultaneous events: a new grant from IDLE may be issued while earlier reads are in flight; tags keep their order. A requester whose req drops in IDLE is simply not considered.
- busy = (state==BURST) or any tag pending.

Optional Feature:
- Macro RNN_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at (last granted index + 1) mod N_REQ, with the pointer reset to N_REQ-1 so requester 0 wins first after reset. The pointer updates on each grant.
- Undefined: fixed priority, lowest index wins. The pointer logic is absent.

Test Plan:
- Read burst: req[1], sel 000, addr 0x010, len 4 -> grant after 1 cycle; mce for 4 cycles with maddr 0x010..0x013; beat_ack×4; done on the 4th beat; rvalid[1] one cycle after each beat, rdata = W_IH[0x010..0x013].
- Write burst: req[0], sel 101, addr 0x0C0, len 64, wdata incrementing -> 64 writes at 0x0C0..0x0FF with mdata_w matching; no rvalid; busy falls one cycle after done.
- Contention: req[0] (len 2) and req[2] (sel 100, len 1) raised together -> req[0] is served first, then one IDLE cycle, then req[2]. With RNN_ARB_RR_EN and req[0] re-requesting continuously, req[2] is granted by the second arbitration.
- Boundary: addr 0x1FFFE, len 3 -> maddr sequence 0x1FFFE, 0x1FFFF, 0x00000. len 0 -> exactly 1 beat. sel 110 -> never granted, mce stays 0.
- Abort and reset: drop req[1] after 2 beats of an 8-beat read -> exactly 2 beats issued and 2 rvalid, no done. Assert reset mid-burst -> all outputs 0 immediately, and no rvalid after reset release.
